// File: rtl/im_boot_loader.sv
// Instruction-memory port owner: passes CPU fetch addresses through in normal
// operation and, on request, stalls the CPU while a byte stream is packed into IM words.
module im_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_we,
  output logic [31:0]       im_wdata,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // Byte handshake: a byte transfers on a rising edge where ld_byte_valid and
  // ld_byte_ready are both 1; ready depends only on state, never on valid.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      last_q  <= last_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    last_d  = last_q;
    count_d = count_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d = S_FILL;
          ptr_d   = '0;
          idx_d   = '0;
          count_d = '0;
          last_d  = 1'b0;
        end
      end
      S_FILL: begin
        if (ld_byte_valid) begin
          if (idx_q == 2'd3) begin
            // Fourth byte completes the word; ld_last only matters here.
            wdata_d = {asm_q, ld_byte};
            last_d  = ld_last;
            idx_d   = '0;
            state_d = S_COMMIT;
          end else begin
            asm_d = {asm_q[15:0], ld_byte};
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_COMMIT: begin
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = (last_q || (ptr_q == LAST_PTR)) ? S_DONE : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_byte_ready = 1'b0;
    cpu_stall     = 1'b1;
    im_we         = 1'b0;
    im_addr       = ptr_q;
    ld_busy       = 1'b0;
    ld_done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_stall = 1'b0;
        im_addr   = cpu_addr;
      end
      S_FILL: begin
        ld_byte_ready = 1'b1;
        ld_busy       = 1'b1;
      end
      S_COMMIT: begin
        im_we   = 1'b1;
        ld_busy = 1'b1;
      end
      default: ld_done = 1'b1;
    endcase
  end

  assign im_wdata  = wdata_q;
  assign ld_count  = count_q;
  assign dbg_state = state_q;

endmodule
